// File: rtl/ps2_packet_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_packet_rx
// Description : PS/2 device-to-host receiver. Frames 11-bit PS/2 words,
//               checks stop and odd parity, assembles multi-byte packets
//               (keyboard 1 byte, mouse 3 bytes) and queues them in a
//               first-word-fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_packet_rx #(
  parameter int PACKET_BYTES   = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit SYNC_CHECK     = 1'b1
) (
  input  logic                               CLOCK_50,
  input  logic                               reset,
  input  logic                               PS2_CLK,
  input  logic                               PS2_DAT,
  input  logic                               flush,
  input  logic                               packet_ready,
  output logic                               packet_valid,
  output logic [8*PACKET_BYTES-1:0]          packet_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               overflow,
  output logic                               parity_error,
  output logic                               framing_error,
  output logic                               timeout_error,
  output logic                               sync_error
);

  localparam int         c_W      = 8 * PACKET_BYTES;
  localparam int         c_PW     = $clog2(FIFO_DEPTH);
  localparam int         c_CW     = $clog2(FIFO_DEPTH + 1);
  localparam int         c_WDW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] c_LAST   = 2'(PACKET_BYTES - 1);
  localparam logic [c_WDW-1:0] c_WD_MAX = c_WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CW-1:0]  c_FULL   = c_CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchronizers; r_clk_d is the one-cycle-delayed synchronized clock.
  logic r_clk_s1, r_clk_s2, r_clk_d, r_dat_s1, r_dat_s2;
  logic w_fall;

  // Frame FSM.
  state_t           r_state;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_shift;
  logic             r_par;
  logic [c_WDW-1:0] r_wd;
  logic             r_byte_ok;
  logic             w_par_bad;

  // Packet assembler.
  logic [1:0]       r_idx;
  logic [7:0]       r_bytes [0:3];
  logic             w_sync_bad;
  logic             w_err_any;
  logic             w_wr;
  logic [c_W-1:0]   w_packet;

  // FIFO.
  logic [c_W-1:0]   r_mem [0:FIFO_DEPTH-1];
  logic [c_PW-1:0]  r_wptr, r_rptr;
  logic [c_CW-1:0]  r_count;
  logic             r_ovf;
  logic             w_pop, w_push;

  // Bring the asynchronous PS/2 lines into the CLOCK_50 domain.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= PS2_DAT;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_d & ~r_clk_s2;
  // Odd parity: an even ones count over data plus parity is an error.
  assign w_par_bad = ~(^{r_shift, r_par});

  // Frame FSM with watchdog; errors and byte strobe are registered pulses.
  always_ff @(posedge CLOCK_50) begin
    if (reset || flush) begin
      r_state       <= S_IDLE;
      r_bitcnt      <= 3'd0;
      r_shift       <= 8'd0;
      r_par         <= 1'b0;
      r_wd          <= '0;
      r_byte_ok     <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      r_byte_ok     <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      timeout_error <= 1'b0;
      if (w_fall || (r_state == S_IDLE)) begin
        r_wd <= '0;
      end else if (r_wd == c_WD_MAX) begin
        r_wd          <= '0;
        r_state       <= S_IDLE;
        timeout_error <= 1'b1;
      end else begin
        r_wd <= r_wd + 1'b1;
      end
      if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!r_dat_s2) begin
              r_state  <= S_DATA;
              r_bitcnt <= 3'd0;
            end
          end
          S_DATA: begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (!r_dat_s2)      framing_error <= 1'b1;
            else if (w_par_bad) parity_error  <= 1'b1;
            else                r_byte_ok     <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_err_any  = parity_error | framing_error | timeout_error;
  assign w_sync_bad = SYNC_CHECK && (r_idx == 2'd0) && !r_shift[3];
  assign w_wr       = r_byte_ok && !w_sync_bad && (r_idx == c_LAST);

  // Collect accepted bytes; any frame error throws away the partial packet.
  always_ff @(posedge CLOCK_50) begin
    if (reset || flush) begin
      r_idx      <= 2'd0;
      sync_error <= 1'b0;
      for (int i = 0; i < 4; i++) r_bytes[i] <= 8'd0;
    end else begin
      sync_error <= 1'b0;
      if (w_err_any) begin
        r_idx <= 2'd0;
      end else if (r_byte_ok) begin
        if (w_sync_bad) begin
          sync_error <= 1'b1;
        end else begin
          r_bytes[r_idx] <= r_shift;
          r_idx          <= (r_idx == c_LAST) ? 2'd0 : r_idx + 2'd1;
        end
      end
    end
  end

  // The final byte comes straight from the shifter so the write needs no extra stage.
  generate
    for (genvar k = 0; k < PACKET_BYTES; k++) begin : g_pack
      if (k == PACKET_BYTES - 1) begin : g_last
        assign w_packet[8*k +: 8] = r_shift;
      end else begin : g_held
        assign w_packet[8*k +: 8] = r_bytes[k];
      end
    end
  endgenerate

  assign w_pop  = (r_count != '0) && packet_ready;
  assign w_push = w_wr && ((r_count != c_FULL) || w_pop);

  // FIFO storage; pointers are reset, contents need not be.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_mem[r_wptr] <= w_packet;
  end

  // FIFO pointers, occupancy and sticky overflow; flush beats write and pop.
  always_ff @(posedge CLOCK_50) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_wr && !w_push) r_ovf <= 1'b1;
    end
  end

  assign packet_valid = (r_count != '0);
  assign packet_data  = packet_valid ? r_mem[r_rptr] : '0;
  assign fifo_count   = r_count;
  assign overflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_packet_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_packet_rx
// Description : Scoreboard bench for ps2_packet_rx. One PS/2 stream drives a
//               mouse-style instance (3 bytes, sync check) and a
//               keyboard-style instance (1 byte, no sync check); a packet
//               level model predicts both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_packet_rx;

  localparam int TO  = 100;
  localparam int H   = 8;
  localparam int GAP = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic flush = 1'b0, ready = 1'b0;

  logic        a_valid, a_ovf, a_perr, a_ferr, a_terr, a_serr;
  logic [23:0] a_data;
  logic [2:0]  a_count;
  logic        b_valid, b_ovf, b_perr, b_ferr, b_terr, b_serr;
  logic [7:0]  b_data;
  logic [2:0]  b_count;

  always #5 clk = ~clk;

  ps2_packet_rx #(.PACKET_BYTES(3), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO), .SYNC_CHECK(1'b1)) u_a (
    .CLOCK_50(clk), .reset(rst), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat), .flush(flush),
    .packet_ready(ready), .packet_valid(a_valid), .packet_data(a_data), .fifo_count(a_count),
    .overflow(a_ovf), .parity_error(a_perr), .framing_error(a_ferr), .timeout_error(a_terr),
    .sync_error(a_serr));

  ps2_packet_rx #(.PACKET_BYTES(1), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO), .SYNC_CHECK(1'b0)) u_b (
    .CLOCK_50(clk), .reset(rst), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat), .flush(flush),
    .packet_ready(ready), .packet_valid(b_valid), .packet_data(b_data), .fifo_count(b_count),
    .overflow(b_ovf), .parity_error(b_perr), .framing_error(b_ferr), .timeout_error(b_terr),
    .sync_error(b_serr));

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: expected FIFO contents, partial packet, expected error counts.
  logic [23:0] q_a [$];
  logic [7:0]  q_b [$];
  logic [7:0]  part [$];
  bit          exp_ovf_a = 1'b0, exp_ovf_b = 1'b0;
  int          exp_err [4];     // 0 parity, 1 framing, 2 timeout, 3 sync
  int          obs_a [4];
  int          obs_b [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input logic [23:0] p);
    if (q_a.size() < 4) q_a.push_back(p);
    else exp_ovf_a = 1'b1;
  endtask

  task automatic push_b(input logic [7:0] p);
    if (q_b.size() < 4) q_b.push_back(p);
    else exp_ovf_b = 1'b1;
  endtask

  task automatic model_good(input logic [7:0] b);
    if (part.size() == 0 && b[3] == 1'b0) begin
      exp_err[3]++;
    end else begin
      part.push_back(b);
      if (part.size() == 3) begin
        push_a({part[2], part[1], part[0]});
        part.delete();
      end
    end
    push_b(b);
  endtask

  task automatic model_err(input int kind);
    exp_err[kind]++;
    part.delete();
  endtask

  // Monitor: count error pulses and pop/compare every packet handed over.
  always @(negedge clk) begin
    if (!rst) begin
      obs_a[0] += int'(a_perr); obs_a[1] += int'(a_ferr);
      obs_a[2] += int'(a_terr); obs_a[3] += int'(a_serr);
      obs_b[0] += int'(b_perr); obs_b[1] += int'(b_ferr);
      obs_b[2] += int'(b_terr); obs_b[3] += int'(b_serr);
      if (a_valid && ready) begin
        if (q_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL a_unexpected: got packet 0x%0h, expected none", a_data);
        end else begin
          check("a_packet", 32'(a_data), 32'(q_a.pop_front()));
        end
      end
      if (b_valid && ready) begin
        if (q_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected: got packet 0x%0h, expected none", b_data);
        end else begin
          check("b_packet", 32'(b_data), 32'(q_b.pop_front()));
        end
      end
    end
  end

  task automatic ps2_bit(input logic v);
    @(negedge clk) ps2_dat = v;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop bit, 3 stall after 4 data bits.
  task automatic send_frame(input logic [7:0] b, input int kind, input bit lat);
    logic p;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (kind == 3 && i == 4) begin
        model_err(2);
        repeat (TO + 20) @(negedge clk);
        ps2_dat = 1'b1;
        repeat (GAP) @(negedge clk);
        return;
      end
      ps2_bit(b[i]);
    end
    p = ~(^b);
    if (kind == 1) p = ~p;
    ps2_bit(p);
    @(negedge clk) ps2_dat = (kind != 2);
    repeat (H) @(negedge clk);
    if (kind == 0) model_good(b);
    else model_err(kind - 1);
    ps2_clk = 1'b0;
    if (lat) begin
      repeat (3) @(posedge clk);
      #1 check("latency_not_early", 32'(a_valid), 32'd0);
      @(posedge clk);
      #1 check("latency_rise", 32'(a_valid), 32'd1);
      repeat (H - 4) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    ps2_clk = 1'b1;
    @(negedge clk) ps2_dat = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk) #1 ready = v;
  endtask

  task automatic do_flush();
    @(posedge clk) #1 flush = 1'b1;
    @(posedge clk) #1 flush = 1'b0;
    q_a.delete(); q_b.delete(); part.delete();
    exp_ovf_a = 1'b0; exp_ovf_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int r;
    logic [7:0] rb;
    for (int i = 0; i < 4; i++) begin exp_err[i] = 0; obs_a[i] = 0; obs_b[i] = 0; end
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_a_count", 32'(a_count), 32'd0);
    check("rst_a_ovf",   32'(a_ovf),   32'd0);
    check("rst_a_data",  32'(a_data),  32'd0);
    check("rst_a_errs",  32'({a_perr, a_ferr, a_terr, a_serr}), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);

    // Keyboard instance: single byte packet held while not ready.
    send_frame(8'h1C, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("kb_count_1", 32'(b_count), 32'd1);
    check("kb_data",    32'(b_data),  32'h1C);
    set_ready(1'b1);
    repeat (5) @(negedge clk);
    check("kb_count_0", 32'(b_count), 32'd0);
    do_flush();

    // Mouse packet with latency measurement on the final stop edge.
    send_frame(8'h08, 0, 1'b0);
    send_frame(8'h05, 0, 1'b0);
    send_frame(8'hFB, 0, 1'b1);

    // Parity error mid-packet, then a clean packet.
    send_frame(8'h08, 0, 1'b0);
    send_frame(8'h05, 1, 1'b0);
    send_frame(8'h08, 0, 1'b0);
    send_frame(8'h01, 0, 1'b0);
    send_frame(8'h02, 0, 1'b0);

    // Stall mid-frame, then a clean packet.
    send_frame(8'h08, 0, 1'b0);
    send_frame(8'hA5, 3, 1'b0);
    send_frame(8'h08, 0, 1'b0);
    send_frame(8'h01, 0, 1'b0);
    send_frame(8'h02, 0, 1'b0);

    // Out-of-sync first byte, bad stop bit, then clean packets.
    send_frame(8'h00, 0, 1'b0);
    send_frame(8'h08, 0, 1'b0);
    send_frame(8'h00, 0, 1'b0);
    send_frame(8'h00, 0, 1'b0);
    send_frame(8'h3C, 2, 1'b0);

    // Random bytes with random error injection.
    for (int n = 0; n < 60; n++) begin
      r  = int'($urandom_range(0, 99));
      rb = 8'($urandom);
      if (r < 8)       send_frame(rb, 1, 1'b0);
      else if (r < 16) send_frame(rb, 2, 1'b0);
      else if (r < 21) send_frame(rb, 3, 1'b0);
      else             send_frame(rb, 0, 1'b0);
    end
    repeat (10) @(negedge clk);
    check("ovf_a_clear", 32'(a_ovf), 32'(exp_ovf_a));
    check("ovf_b_clear", 32'(b_ovf), 32'(exp_ovf_b));

    // Fill past capacity with the consumer stalled.
    do_flush();
    set_ready(1'b0);
    for (int n = 0; n < 5; n++) begin
      send_frame(8'($urandom) | 8'h08, 0, 1'b0);
      send_frame(8'($urandom), 0, 1'b0);
      send_frame(8'($urandom), 0, 1'b0);
    end
    repeat (5) @(negedge clk);
    check("full_a_count", 32'(a_count), 32'd4);
    check("full_a_ovf",   32'(a_ovf),   32'd1);
    check("full_a_head",  32'(a_data),  32'(q_a[0]));
    check("full_b_count", 32'(b_count), 32'd4);
    check("full_b_ovf",   32'(b_ovf),   32'd1);
    check("full_b_head",  32'(b_data),  32'(q_b[0]));
    do_flush();
    @(negedge clk);
    check("flush_a_count", 32'(a_count), 32'd0);
    check("flush_a_ovf",   32'(a_ovf),   32'd0);
    check("flush_a_valid", 32'(a_valid), 32'd0);
    check("flush_b_count", 32'(b_count), 32'd0);
    check("flush_b_ovf",   32'(b_ovf),   32'd0);

    set_ready(1'b1);
    send_frame(8'h08, 0, 1'b0);
    send_frame(8'h01, 0, 1'b0);
    send_frame(8'h02, 0, 1'b0);
    repeat (20) @(negedge clk);

    check("a_drained", 32'(q_a.size()), 32'd0);
    check("b_drained", 32'(q_b.size()), 32'd0);
    check("a_parity_cnt",  32'(obs_a[0]), 32'(exp_err[0]));
    check("a_framing_cnt", 32'(obs_a[1]), 32'(exp_err[1]));
    check("a_timeout_cnt", 32'(obs_a[2]), 32'(exp_err[2]));
    check("a_sync_cnt",    32'(obs_a[3]), 32'(exp_err[3]));
    check("b_parity_cnt",  32'(obs_b[0]), 32'(exp_err[0]));
    check("b_framing_cnt", 32'(obs_b[1]), 32'(exp_err[1]));
    check("b_timeout_cnt", 32'(obs_b[2]), 32'(exp_err[2]));
    check("b_sync_cnt",    32'(obs_b[3]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
